// File: rtl/mult_div_if.sv
// -----------------------------------------------------------------------------
// mult_div_if
// Request/result bundle between the execute-stage controller and the
// multiply/divide unit.
//
//   start  controller -> unit   request strobe, sampled with op/SrcA/SrcB
//   op     controller -> unit   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO
//   SrcA   controller -> unit   multiplicand / dividend / MTHI-MTLO data
//   SrcB   controller -> unit   multiplier / divisor
//   busy   unit -> controller   operation in flight, stall HI/LO users
//   hi     unit -> controller   HI register
//   lo     unit -> controller   LO register
// -----------------------------------------------------------------------------
interface mult_div_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, SrcA, SrcB,
        input  busy, hi, lo
    );

    modport slave (
        input  start, op, SrcA, SrcB,
        output busy, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
// Multi-cycle multiply/divide unit with HI/LO result registers. The result is
// computed combinationally from operands captured at the start edge and is
// committed to HI/LO after a fixed per-class latency; busy covers that window.
//
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    mult_div_if.slave: start/op/SrcA/SrcB in, busy/hi/lo out
//
// Parameters: WIDTH (operand width), MULT_CYCLES, DIV_CYCLES (busy cycles, >=1)
// -----------------------------------------------------------------------------
module mult_div_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic        clk,
    input logic        rst_n,
    mult_div_if.slave  bus
);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [0:0]       state;
    logic [CNT_W-1:0] count;
    // op_q[1] selects divide, op_q[0] selects the unsigned variant.
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic             is_signed;
    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;
    logic [2*WIDTH-1:0] product;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH-1:0] quot_mag;
    logic [WIDTH-1:0] rem_mag;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;

    // Result datapath. Works only on captured operands, so later changes on
    // SrcA/SrcB cannot disturb an operation in flight.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves a value held, which would infer a latch.
        is_signed = ~op_q[0];
        a_neg     = is_signed & a_q[WIDTH-1];
        b_neg     = is_signed & b_q[WIDTH-1];

        // Sign- or zero-extend to 2W; the low 2W bits of the product are then
        // correct for both signed and unsigned multiply.
        a_ext   = {{WIDTH{a_neg}}, a_q};
        b_ext   = {{WIDTH{b_neg}}, b_q};
        product = a_ext * b_ext;

        // Signed divide via magnitudes. Signed-min has magnitude 2^(W-1) as an
        // unsigned value, so min / -1 falls out as quotient min, remainder 0.
        abs_a    = a_neg ? (~a_q + 1'b1) : a_q;
        abs_b    = b_neg ? (~b_q + 1'b1) : b_q;
        quot_mag = '0;
        rem_mag  = '0;
        if (b_q != '0) begin
            quot_mag = abs_a / abs_b;
            rem_mag  = abs_a % abs_b;
        end

        res_hi = product[2*WIDTH-1:WIDTH];
        res_lo = product[WIDTH-1:0];
        if (op_q[1]) begin
            if (b_q == '0) begin
                res_lo = '1;
                res_hi = a_q;
            end else begin
                res_lo = (a_neg ^ b_neg) ? (~quot_mag + 1'b1) : quot_mag;
                res_hi = a_neg ? (~rem_mag + 1'b1) : rem_mag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: nonblocking assignments throughout sequential logic so every
            // flop samples pre-edge values regardless of statement order.
            state <= IDLE;
            count <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        case (bus.op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                a_q   <= bus.SrcA;
                                b_q   <= bus.SrcB;
                                op_q  <= bus.op[1:0];
                                count <= bus.op[1] ? DIV_LOAD : MULT_LOAD;
                                state <= RUN;
                            end
                            OP_MTHI: hi_q <= bus.SrcA;
                            OP_MTLO: lo_q <= bus.SrcA;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    // Count holds N at the first RUN edge, so reaching 1 marks
                    // edge E0+N where the result commits. start is ignored here.
                    if (count == CNT_ONE) begin
                        hi_q  <= res_hi;
                        lo_q  <= res_lo;
                        count <= '0;
                        state <= IDLE;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule
